// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-requester I2C EEPROM arbiter.
package i2c_arb_pkg;

    localparam int ADDR_W             = 8;
    localparam int DATA_W             = 8;
    localparam int GAP_CYCLES_DEF     = 100;
    localparam int TIMEOUT_CYCLES_DEF = 65535;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_WAIT_RELEASE,
        ST_GAP
    } state_t;

endpackage

// File: rtl/i2c_arb_rr.sv
// Two-way round-robin grant: the requester not served last wins a tie.
module i2c_arb_rr (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    // last_gnt = 1 means requester 1 was served most recently
    always_comb begin
        gnt[0] = req0 && (!req1 || last_gnt);
        gnt[1] = req1 && (!req0 || !last_gnt);
    end

endmodule

// File: rtl/i2c_arb.sv
// Arbitrates two requesters onto one I2C master with enforced idle gaps.
// Optional op_done watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | waiting for a request (and for post-reset gap to expire)
// ISSUE        | selected op driven low with captured addr/data
// WAIT_DONE    | op held low until the master raises i2c_op_done
// WAIT_RELEASE | op high, waiting for i2c_op_done to fall
// GAP          | GAP_CYCLES idle clocks before the next grant
module i2c_arb
    import i2c_arb_pkg::*;
#(
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              i2c_write_op,
    output logic              i2c_read_op,
    output logic [ADDR_W-1:0] i2c_addr,
    output logic [DATA_W-1:0] i2c_write_data,
    input  logic [DATA_W-1:0] i2c_read_data,
    input  logic              i2c_op_done
);

    if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("i2c_arb: GAP_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t            state;
    state_t            next_state;
    logic [GAP_W-1:0]  gap_cnt;
    logic [1:0]        gnt;
    logic              last_gnt;
    logic              sel;
    logic              we_q;
    logic              grant_we;
    logic              op_we;
    logic              op_next;
    logic              finish;
    logic              timeout;
    logic [DATA_W-1:0] rd_lat;

    i2c_arb_rr u_rr (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
        end else if ((state == ST_WAIT_DONE || state == ST_WAIT_RELEASE) && to_cnt != '0) begin
            to_cnt <= to_cnt - TO_W'(1);
        end
    end

    assign timeout = (state == ST_WAIT_DONE || state == ST_WAIT_RELEASE) && (to_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            err0 <= 1'b0;
            err1 <= 1'b0;
        end else begin
            err0 <= finish && timeout && !sel;
            err1 <= finish && timeout && sel;
        end
    end
`else
    assign timeout = 1'b0;
    assign err0    = 1'b0;
    assign err1    = 1'b0;
`endif

    always_comb begin
        grant_we   = gnt[1] ? we1 : we0;
        op_we      = (state == ST_IDLE) ? grant_we : we_q;
        next_state = state;
        case (state)
            ST_IDLE:         if (gap_cnt == '0 && gnt != 2'b00) next_state = ST_ISSUE;
            ST_ISSUE:        next_state = ST_WAIT_DONE;
            ST_WAIT_DONE:    if (timeout) next_state = ST_GAP;
                             else if (i2c_op_done) next_state = ST_WAIT_RELEASE;
            ST_WAIT_RELEASE: if (timeout || !i2c_op_done) next_state = ST_GAP;
            ST_GAP:          if (gap_cnt == '0) next_state = ST_IDLE;
            default:         next_state = ST_IDLE;
        endcase
        op_next = (next_state == ST_ISSUE) || (next_state == ST_WAIT_DONE);
        finish  = (next_state == ST_GAP) && (state != ST_GAP);
    end

    // Outputs are registered from next_state so the ops never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            gap_cnt        <= GAP_LOAD;
            last_gnt       <= 1'b1;
            sel            <= 1'b0;
            we_q           <= 1'b0;
            rd_lat         <= '0;
            i2c_write_op   <= 1'b1;
            i2c_read_op    <= 1'b1;
            i2c_addr       <= '0;
            i2c_write_data <= '0;
            done0          <= 1'b0;
            done1          <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
        end else begin
            state <= next_state;
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (state == ST_IDLE && next_state == ST_ISSUE) begin
                sel            <= gnt[1];
                last_gnt       <= gnt[1];
                we_q           <= grant_we;
                i2c_addr       <= gnt[1] ? addr1 : addr0;
                i2c_write_data <= gnt[1] ? wdata1 : wdata0;
            end
            if (finish) begin
                gap_cnt <= GAP_LAST;
            end else if ((state == ST_GAP || state == ST_IDLE) && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            i2c_write_op <= ~(op_next & op_we);
            i2c_read_op  <= ~(op_next & ~op_we);
            if (state == ST_WAIT_DONE && i2c_op_done) begin
                rd_lat <= i2c_read_data;
            end
            if (finish) begin
                if (sel) done1 <= 1'b1;
                else     done0 <= 1'b1;
                if (!timeout && !we_q) begin
                    if (sel) rdata1 <= rd_lat;
                    else     rdata0 <= rd_lat;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_arb.sv
// Bench for i2c_arb: EEPROM-like master model, vector table, randomized fairness run.
module tb_i2c_arb;

    localparam int GAP = 5;
    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       done0, done1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       i2c_write_op, i2c_read_op;
    logic [7:0] i2c_addr, i2c_write_data, i2c_read_data;
    logic       i2c_op_done;

    always #5 clk = ~clk;

    i2c_arb #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .i2c_write_op(i2c_write_op), .i2c_read_op(i2c_read_op),
        .i2c_addr(i2c_addr), .i2c_write_data(i2c_write_data),
        .i2c_read_data(i2c_read_data), .i2c_op_done(i2c_op_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- EEPROM / I2C master model ----------------
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    bit         stall = 1'b0;
    int         m_st, m_lat, cyc, fall_cyc, gap_meas, op_starts;
    bit         m_we;
    logic [7:0] m_addr, m_wd;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        i2c_op_done   = 1'b0;
        i2c_read_data = 8'h00;
        m_st = 0; m_lat = 0; cyc = 0; fall_cyc = -1000; gap_meas = 0; op_starts = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                m_st        = 0;
                i2c_op_done = 1'b0;
            end else begin
                case (m_st)
                    0: if (!i2c_write_op || !i2c_read_op) begin
                        op_starts++;
                        check("ops_exclusive", {31'd0, (i2c_write_op | i2c_read_op)}, 1);
                        if (fall_cyc > 0) begin
                            gap_meas = cyc - fall_cyc;
                            check("min_gap", {31'd0, (gap_meas >= GAP)}, 1);
                        end
                        m_we   = !i2c_write_op;
                        m_addr = i2c_addr;
                        m_wd   = i2c_write_data;
                        if (m_we) i2c_read_data = 8'($urandom);
                        m_lat  = $urandom_range(1, 4);
                        m_st   = 1;
                    end
                    1: if (!stall) begin
                        if (m_lat == 0) begin
                            check("addr_stable_issue", {24'd0, i2c_addr}, {24'd0, m_addr});
                            if (m_we) mem[m_addr] = m_wd;
                            else      i2c_read_data = mem[m_addr];
                            i2c_op_done = 1'b1;
                            m_st = 2;
                        end else begin
                            m_lat--;
                        end
                    end
                    2: if (i2c_write_op && i2c_read_op) begin
                        m_lat = $urandom_range(0, 3);
                        m_st  = 3;
                    end
                    default: if (m_lat == 0) begin
                        check("data_stable_release", {16'd0, i2c_addr, i2c_write_data},
                              {16'd0, m_addr, m_wd});
                        i2c_op_done = 1'b0;
                        fall_cyc    = cyc;
                        m_st        = 0;
                    end else begin
                        m_lat--;
                    end
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] prev_rd [2];
    int         last_served;

    task automatic set_req(input int r, input bit on, input bit we, input logic [7:0] a,
                           input logic [7:0] wd);
        if (r == 0) begin req0 = on; we0 = we; addr0 = a; wdata0 = wd; end
        else        begin req1 = on; we1 = we; addr1 = a; wdata1 = wd; end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ops"}, {30'd0, i2c_write_op, i2c_read_op}, 32'h3);
        check({tag, "_addr_wdata"}, {16'd0, i2c_addr, i2c_write_data}, 0);
        check({tag, "_done_err"}, {28'd0, done0, done1, err0, err1}, 0);
        check({tag, "_rdata"}, {16'd0, rdata0, rdata1}, 0);
    endtask

    // Expected rdata: reads return the reference memory, writes leave rdataN untouched.
    function automatic logic [7:0] expect_rd(input int r, input bit we, input logic [7:0] a,
                                             input logic [7:0] wd);
        if (we) begin
            ref_mem[a] = wd;
            return prev_rd[r];
        end
        prev_rd[r] = ref_mem[a];
        return ref_mem[a];
    endfunction

    task automatic do_op(input int r, input bit we, input logic [7:0] a, input logic [7:0] wd,
                         input logic [7:0] exp_rd, output int lat);
        int n;
        logic [7:0] want;
        set_req(r, 1'b1, we, a, wd);
        lat = 0;
        while (i2c_write_op && i2c_read_op && lat < 300) begin @(negedge clk); lat++; end
        check("op_started", {31'd0, (lat < 300)}, 1);
        check("op_kind", {31'd0, (we ? i2c_write_op : i2c_read_op)}, 0);
        check("op_addr", {24'd0, i2c_addr}, {24'd0, a});
        if (we) check("op_wdata", {24'd0, i2c_write_data}, {24'd0, wd});
        n = 0;
        while (!(r == 1 ? done1 : done0) && n < 300) begin @(negedge clk); n++; end
        check("done_seen", {31'd0, (n < 300)}, 1);
        check("done_other_quiet", {31'd0, (r == 1 ? done0 : done1)}, 0);
        check("err_clear", {30'd0, err0, err1}, 0);
        want = expect_rd(r, we, a, wd);
        if (!we) check("table_rdata_const", {24'd0, want}, {24'd0, exp_rd});
        check("rdata", {24'd0, (r == 1 ? rdata1 : rdata0)}, {24'd0, want});
        set_req(r, 1'b0, we, a, wd);
        last_served = r;
        @(negedge clk);
        check("done_one_cycle", {30'd0, done0, done1}, 0);
    endtask

    typedef struct {
        int         r;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [9];
    bit         cur_we [2];
    logic [7:0] cur_a [2];
    logic [7:0] cur_wd [2];

    initial begin
        int lat, n, r, exp_r, starts, pulses;
        logic [7:0] want;

        vecs[0] = '{0, 1'b1, 8'h55, 8'hAA, 8'h00};
        vecs[1] = '{1, 1'b0, 8'h55, 8'h00, 8'hAA};
        vecs[2] = '{1, 1'b1, 8'h10, 8'h3C, 8'h00};
        vecs[3] = '{0, 1'b0, 8'h10, 8'h00, 8'h3C};
        vecs[4] = '{0, 1'b0, 8'h55, 8'h00, 8'hAA};
        vecs[5] = '{1, 1'b1, 8'h55, 8'h12, 8'h00};
        vecs[6] = '{0, 1'b0, 8'h55, 8'h00, 8'h12};
        vecs[7] = '{1, 1'b0, 8'h10, 8'h00, 8'h3C};
        vecs[8] = '{0, 1'b0, 8'h00, 8'h00, 8'h00};

        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        prev_rd[0] = 8'h00; prev_rd[1] = 8'h00; last_served = 1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        // Table: first vector is raised the cycle reset drops, so it also times the post-reset gap.
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].r, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, lat);
            if (i == 0) check("post_reset_latency", lat, GAP + 1);
        end

        // Both requesters held busy: grants must alternate with the minimum gap each time.
        for (int k = 0; k < 2; k++) begin
            cur_we[k] = 1'($urandom); cur_a[k] = 8'($urandom_range(0, 7)); cur_wd[k] = 8'($urandom);
            set_req(k, 1'b1, cur_we[k], cur_a[k], cur_wd[k]);
        end
        exp_r = 1 - last_served;
        for (int k = 0; k < 16; k++) begin
            n = 0;
            while (!(done0 || done1) && n < 300) begin @(negedge clk); n++; end
            check("rr_done_seen", {31'd0, (n < 300)}, 1);
            r = done1 ? 1 : 0;
            check("rr_order", {30'd0, done1, done0}, (exp_r == 1) ? 2 : 1);
            check("rr_err", {30'd0, err0, err1}, 0);
            want = expect_rd(exp_r, cur_we[exp_r], cur_a[exp_r], cur_wd[exp_r]);
            check("rr_rdata", {24'd0, (exp_r == 1 ? rdata1 : rdata0)}, {24'd0, want});
            if (k > 0) check("rr_exact_gap", gap_meas, GAP + 2);
            cur_we[exp_r] = 1'($urandom); cur_a[exp_r] = 8'($urandom_range(0, 7));
            cur_wd[exp_r] = 8'($urandom);
            set_req(exp_r, 1'b1, cur_we[exp_r], cur_a[exp_r], cur_wd[exp_r]);
            last_served = exp_r;
            exp_r = 1 - exp_r;
            @(negedge clk);
            check("rr_done_one_cycle", {30'd0, done0, done1}, 0);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (GAP + 8) @(negedge clk);
        // the op already in flight when reqs dropped finishes; absorb it
        if (!(i2c_write_op && i2c_read_op) || i2c_op_done) begin
            n = 0;
            while (!(done0 || done1) && n < 300) begin @(negedge clk); n++; end
            r = done1 ? 1 : 0;
            want = expect_rd(r, cur_we[r], cur_a[r], cur_wd[r]);
            check("late_done_rdata", {24'd0, (r == 1 ? rdata1 : rdata0)}, {24'd0, want});
            repeat (GAP + 4) @(negedge clk);
        end

        // A request withdrawn during GAP is never served.
        do_op(0, 1'b1, 8'h30, 8'h77, 8'h00, lat);
        starts = op_starts;
        set_req(1, 1'b1, 1'b0, 8'h30, 8'h00);
        @(negedge clk);
        req1 = 1'b0;
        repeat (GAP + 10) @(negedge clk);
        check("dropped_req_not_served", op_starts - starts, 0);

        // A request withdrawn after grant still completes.
        set_req(0, 1'b1, 1'b0, 8'h30, 8'h00);
        n = 0;
        while (i2c_write_op && i2c_read_op && n < 300) begin @(negedge clk); n++; end
        req0 = 1'b0;
        n = 0;
        while (!done0 && n < 300) begin @(negedge clk); n++; end
        check("drop_after_grant_done", {31'd0, done0}, 1);
        want = expect_rd(0, 1'b0, 8'h30, 8'h00);
        check("drop_after_grant_rdata", {24'd0, rdata0}, {24'd0, want});
        repeat (GAP + 4) @(negedge clk);

        // Reset while waiting for op_done.
        stall = 1'b1;
        set_req(0, 1'b1, 1'b0, 8'h30, 8'h00);
        n = 0;
        while (i2c_write_op && i2c_read_op && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("pre_reset_op_low", {31'd0, i2c_read_op}, 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midop_reset");
        req0 = 1'b0;
        rst  = 1'b0;
        stall = 1'b0;
        prev_rd[0] = 8'h00; prev_rd[1] = 8'h00; last_served = 1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0 || done1) pulses++;
        end
        check("midop_reset_no_done", pulses, 0);

        // op_done stuck low.
        stall = 1'b1;
        set_req(0, 1'b1, 1'b1, 8'h40, 8'h5A);
        n = 0;
        while (i2c_write_op && i2c_read_op && n < 300) begin @(negedge clk); n++; end
        check("stuck_op_started", {31'd0, i2c_write_op}, 0);
`ifdef I2C_ARB_TIMEOUT_EN
        n = 0;
        while (!done0 && n < 300) begin @(negedge clk); n++; end
        check("timeout_latency_window", {31'd0, (n >= TMO && n <= TMO + 2)}, 1);
        check("timeout_err", {30'd0, err0, err1}, 2);
        check("timeout_ops_high", {30'd0, i2c_write_op, i2c_read_op}, 3);
`else
        pulses = 0;
        repeat (4 * TMO) begin
            @(negedge clk);
            if (done0 || done1) pulses++;
        end
        check("no_timeout_op_held", {31'd0, i2c_write_op}, 0);
        check("no_timeout_no_done", pulses, 0);
`endif
        req0 = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
